// File: rtl/usi_bus_pkg.sv
// Shared definitions for the USI bus master arbiter: FSM encoding and bus constants.
package usi_bus_pkg;

    localparam int unsigned UsiDataWidth      = 32;
    localparam int unsigned UsiTimeoutDefault = 255;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRCmd,
        StRWait,
        StDone
    } usiStateT;

endpackage

// File: rtl/usi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rrPtr, wrapping.
module usi_rr_arbiter #(
    parameter int unsigned pReqNum = 2,
    parameter int unsigned IdxW    = $clog2(pReqNum)
) (
    input  logic [pReqNum-1:0] reqVec,
    input  logic [IdxW-1:0]    rrPtr,
    output logic               grantVd,
    output logic [IdxW-1:0]    grantIdx
);

    logic [IdxW-1:0] cand;

    always_comb begin
        grantVd  = 1'b0;
        grantIdx = '0;
        cand     = '0;
        for (int k = 0; k < int'(pReqNum); k++) begin
            cand = IdxW'((int'(rrPtr) + k) % int'(pReqNum));
            if (!grantVd && reqVec[cand]) begin
                grantVd  = 1'b1;
                grantIdx = cand;
            end
        end
    end

endmodule

// File: rtl/usi_bus_arbiter.sv
// Shares the USI master port between pReqNum requesters; one USI transaction per grant,
// read responses awaited with a timeout.
module usi_bus_arbiter
    import usi_bus_pkg::*;
#(
    parameter int unsigned pReqNum          = 2,
    parameter int unsigned pUsiBusWidth     = 16,
    parameter int unsigned pBlockConnectNum = 1,
    parameter int unsigned pTimeoutCycles   = UsiTimeoutDefault
) (
    input  logic                              iSCLK,
    input  logic                              iSRST,
    input  logic [pReqNum-1:0]                iReqVd,
    input  logic [pReqNum-1:0]                iReqWr,
    input  logic [pReqNum*pUsiBusWidth-1:0]   iReqAdrs,
    input  logic [pReqNum*UsiDataWidth-1:0]   iReqWd,
    output logic [pReqNum-1:0]                oReqDone,
    output logic                              oReqErr,
    output logic [UsiDataWidth-1:0]           oReqRd,
    output logic [UsiDataWidth-1:0]           oMUsiWd,
    output logic [pUsiBusWidth-1:0]           oMUsiAdrs,
    output logic                              oMUsiWEd,
    output logic                              oMUsiRCmd,
    input  logic [UsiDataWidth-1:0]           iMUsiRd,
    input  logic [pBlockConnectNum-1:0]       iMUsiREd
);

    localparam int unsigned IdxW = $clog2(pReqNum);
    localparam int unsigned CntW = $clog2(pTimeoutCycles + 1);

    usiStateT                stateQ, stateD;
    logic [IdxW-1:0]         rrPtrQ, rrPtrD;
    logic [IdxW-1:0]         idxQ, idxD;
    logic [pUsiBusWidth-1:0] adrsQ, adrsD;
    logic [UsiDataWidth-1:0] wdQ, wdD;
    logic [UsiDataWidth-1:0] rdQ, rdD;
    logic [CntW-1:0]         cntQ, cntD, cntInc;
    logic                    errQ, errD;

    logic                    grantVd;
    logic [IdxW-1:0]         grantIdx;
    logic [pUsiBusWidth-1:0] selAdrs;
    logic [UsiDataWidth-1:0] selWd;

    usi_rr_arbiter #(
        .pReqNum (pReqNum),
        .IdxW    (IdxW)
    ) uRrArbiter (
        .reqVec   (iReqVd),
        .rrPtr    (rrPtrQ),
        .grantVd  (grantVd),
        .grantIdx (grantIdx)
    );

    // Constant-index mux keeps the packed slice selection lint-clean.
    always_comb begin
        selAdrs = '0;
        selWd   = '0;
        for (int i = 0; i < int'(pReqNum); i++) begin
            if (grantIdx == IdxW'(i)) begin
                selAdrs = iReqAdrs[i*pUsiBusWidth +: pUsiBusWidth];
                selWd   = iReqWd[i*UsiDataWidth +: UsiDataWidth];
            end
        end
    end

    assign cntInc = cntQ + CntW'(1);

    always_comb begin
        stateD = stateQ;
        rrPtrD = rrPtrQ;
        idxD   = idxQ;
        adrsD  = adrsQ;
        wdD    = wdQ;
        rdD    = rdQ;
        cntD   = cntQ;
        errD   = errQ;
        unique case (stateQ)
            StIdle: begin
                if (grantVd) begin
                    idxD   = grantIdx;
                    adrsD  = selAdrs;
                    wdD    = selWd;
                    rdD    = '0;
                    errD   = 1'b0;
                    stateD = iReqWr[grantIdx] ? StWrite : StRCmd;
                end
            end
            StWrite: stateD = StDone;
            StRCmd: begin
                cntD   = '0;
                stateD = StRWait;
            end
            StRWait: begin
                if (|iMUsiREd) begin
                    rdD    = iMUsiRd;
                    stateD = StDone;
                end else begin
                    cntD = cntInc;
                    if (cntInc == CntW'(pTimeoutCycles)) begin
                        rdD    = '0;
                        errD   = 1'b1;
                        stateD = StDone;
                    end
                end
            end
            StDone: begin
                rrPtrD = (idxQ == IdxW'(pReqNum - 1)) ? '0 : idxQ + IdxW'(1);
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge iSCLK or negedge iSRST) begin
        if (!iSRST) begin
            stateQ <= StIdle;
            rrPtrQ <= '0;
            idxQ   <= '0;
            adrsQ  <= '0;
            wdQ    <= '0;
            rdQ    <= '0;
            cntQ   <= '0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            rrPtrQ <= rrPtrD;
            idxQ   <= idxD;
            adrsQ  <= adrsD;
            wdQ    <= wdD;
            rdQ    <= rdD;
            cntQ   <= cntD;
            errQ   <= errD;
        end
    end

    // Outputs decode straight from registered state so reset clears them immediately.
    always_comb begin
        oMUsiWEd  = (stateQ == StWrite);
        oMUsiRCmd = (stateQ == StRCmd);
        oMUsiAdrs = (oMUsiWEd || oMUsiRCmd) ? adrsQ : '0;
        oMUsiWd   = oMUsiWEd ? wdQ : '0;
        oReqErr   = (stateQ == StDone) && errQ;
        oReqRd    = (stateQ == StDone) ? rdQ : '0;
        oReqDone  = '0;
        for (int i = 0; i < int'(pReqNum); i++) begin
            oReqDone[i] = (stateQ == StDone) && (idxQ == IdxW'(i));
        end
    end

endmodule
